spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
- Shares one spi_master instance between NUM_REQ independent requesters using round-robin arbitration.
- Latches the winner's transmit byte and drives a one-cycle start pulse into spi_master.
- Waits for spi_master's finish, returns the received byte to the winner, then enforces a minimum idle gap before the next grant.
- Sits between client blocks (sensor readers, config loaders) and spi_master; also exports the winner index for external chip-select steering.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, SPI word width; must equal spi_master DATA_WIDTH.
- GAP_CYCLES, 2, clk cycles of forced idle between transfers (0 allowed).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. Top level drives spi_master rst_n = ~rst.
- req  in  NUM_REQ  level request per requester; held until done.
- req_data  in  NUM_REQ*DATA_WIDTH  packed TX words; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot, high for the whole transfer.
- done  out  NUM_REQ  one-hot, 1-cycle pulse at completion.
- rdata  out  DATA_WIDTH  received word; valid in the done cycle and held until the next done.
- sel_idx  out  $clog2(NUM_REQ)  binary index of the current/last winner.
- busy  out  1  high in every state other than IDLE.
- m_start  out  1  to spi_master start; 1-cycle pulse.
- m_data_in  out  DATA_WIDTH  to spi_master data_in; stable from m_start until finish.
- m_finish  in  1  from spi_master finish.
- m_data_out  in  DATA_WIDTH  from spi_master data_out.

Behaviour:
- Reset values: gnt=0, done=0, rdata=0, sel_idx=0, busy=0, m_start=0, m_data_in=0, rr pointer=0, state=IDLE, finish-edge register=0. Reset mid-transfer abandons the transfer silently; no done is issued.
- FSM IDLE -> START -> WAIT -> DONE -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0.
- IDLE:
  - If any req is high, pick the first set bit searching from the rr pointer upward with wrap.
  - Next cycle: gnt[w]=1, sel_idx=w, m_data_in=req_data slice w, m_start=1, state=START.
  - Request-to-m_start latency is exactly 1 cycle.
- START: lasts 1 cycle; m_start returns to 0; go to WAIT.
- WAIT:
  - Completion is the rising edge of m_finish (m_finish=1 and its registered previous value=0). A level already high on entry is ignored.
  - On completion: capture m_data_out into rdata, go to DONE.
- DONE: lasts 1 cycle.
  - done[w]=1 and gnt[w]=1 in this cycle.
  - rr pointer becomes (w+1) mod NUM_REQ.
  - Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: gnt=0; count GAP_CYCLES cycles, then IDLE. Requests are not sampled during GAP.
- gnt drops in the cycle after done.
- If req[w] deasserts mid-transfer, the transfer still completes and done[w] still pulses. The requester ignores it.
- If req[w] is still high after done, it loses priority to any other active requester. If it is the only requester, it is re-granted after the gap.
- req_data changes after grant have no effect; m_data_in stays latched.
- Fairness bound: with N requesters continuously active, each is served at least once every N transfers.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- When defined:
  - Adds output err (NUM_REQ, one-hot pulse).
  - A counter runs in WAIT. Reaching TIMEOUT_CYCLES without a finish edge forces DONE with done[w]=1, err[w]=1, and rdata unchanged.
  - The counter clears on every START.
- When undefined: no err port and no counter; WAIT waits indefinitely.

Decomposition:
- Package spi_arb_pkg: state enum (IDLE, START, WAIT, DONE, GAP) and the function for index width ($clog2 of NUM_REQ, minimum 1).
- One sub-module, spi_rr_picker: combinational round-robin first-one search from the pointer with wrap. Inputs are req and ptr; outputs are one-hot winner, index, and any.
- FSM, data latches and counters stay in the top module.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5; spi_master returns 8'h3C -> m_start one cycle after req with m_data_in=8'hA5; done=4'b0001 with rdata=8'h3C; GAP lasts 2 cycles; busy falls.
- All requesters active, req=4'b1111 held -> grant order 0,1,2,3,0; each m_data_in matches its slice; never two transfers in a row to the same requester.
- Pointer wrap: finish a transfer for requester 3, then assert req=4'b1001 -> requester 0 wins (pointer wrapped to 0).
- Drop request mid-transfer: req[1] asserted, then deasserted during WAIT -> transfer completes and done[1] still pulses; next grant goes to another requester.
- Reset mid-transfer: assert rst for 1 cycle during WAIT -> next cycle all outputs are 0 and state is IDLE; a later request to requester 2 produces m_start normally.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: m_finish tied low -> done[w] and err[w] pulse 16 cycles after START; rdata unchanged.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, GAP} arb_state_t;

    // Index width for a field holding values 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Client-side bus of the SPI master arbiter: requests, grants and returned data.
// Optional SPI_ARB_TIMEOUT_EN adds the err pulse vector.
interface spi_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = spi_arb_pkg::idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [IDX_W-1:0]              sel_idx;
    logic                          busy;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0]            err;
`endif

    modport slave (
        input  req, req_data,
`ifdef SPI_ARB_TIMEOUT_EN
        output err,
`endif
        output gnt, done, rdata, sel_idx, busy
    );

    modport master (
        output req, req_data,
`ifdef SPI_ARB_TIMEOUT_EN
        input  err,
`endif
        input  gnt, done, rdata, sel_idx, busy
    );

endinterface

// File: rtl/spi_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module spi_rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            automatic int j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j[IDX_W-1:0]]) begin
                win[j[IDX_W-1:0]] = 1'b1;
                idx               = j[IDX_W-1:0];
                any               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one spi_master among NUM_REQ clients, with a forced idle gap.
// Define SPI_ARB_TIMEOUT_EN to add the WAIT watchdog and the err output.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_arbiter_if.slave   cli,
    output logic                  m_rst_n,
    output logic                  m_start,
    output logic [DATA_WIDTH-1:0] m_data_in,
    input  logic                  m_finish,
    input  logic [DATA_WIDTH-1:0] m_data_out
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int GAP_W = idx_w(GAP_CYCLES + 1);

    arb_state_t            state;
    logic [NUM_REQ-1:0]    gnt_q, done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      sel_q, rr_ptr;
    logic                  busy_q, fin_q;
    logic [GAP_W-1:0]      gap_cnt;

    logic [NUM_REQ-1:0]    pick_win;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = idx_w(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]       to_cnt;
    logic [NUM_REQ-1:0]    err_q;
    assign cli.err = err_q;
`endif

    spi_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req (cli.req),
        .ptr (rr_ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign m_rst_n     = ~rst;
    assign cli.gnt     = gnt_q;
    assign cli.done    = done_q;
    assign cli.rdata   = rdata_q;
    assign cli.sel_idx = sel_q;
    assign cli.busy    = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            m_start   <= 1'b0;
            m_data_in <= '0;
            rr_ptr    <= '0;
            fin_q     <= 1'b0;
            gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= '0;
`endif
        end else begin
            // Previous m_finish level, so only a fresh rising edge completes WAIT.
            fin_q  <= m_finish;
            done_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= START;
                        gnt_q     <= pick_win;
                        sel_q     <= pick_idx;
                        m_data_in <= cli.req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        m_start   <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                START: begin
                    m_start <= 1'b0;
                    state   <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt  <= to_cnt + 1'b1;
`endif
                end
                WAIT: begin
                    if (m_finish && !fin_q) begin
                        rdata_q <= m_data_out;
                        done_q  <= gnt_q;
                        state   <= DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Watchdog expiry completes the transfer with rdata left untouched.
                    else if (int'(to_cnt) >= TIMEOUT_CYCLES - 1) begin
                        done_q <= gnt_q;
                        err_q  <= gnt_q;
                        state  <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    gnt_q   <= '0;
                    gap_cnt <= '0;
                    if (int'(sel_q) == NUM_REQ - 1) rr_ptr <= '0;
                    else                            rr_ptr <= sel_q + 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (int'(gap_cnt) >= GAP_CYCLES - 1) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a timeline model of the transfer sequence.
module tb_spi_master_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int TO  = 16;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) cli ();

    logic          m_rst_n, m_start;
    logic          m_finish   = 1'b0;
    logic [DW-1:0] m_data_in;
    logic [DW-1:0] m_data_out = '0;

    spi_master_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cli        (cli),
        .m_rst_n    (m_rst_n),
        .m_start    (m_start),
        .m_data_in  (m_data_in),
        .m_finish   (m_finish),
        .m_data_out (m_data_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Simple spi_master stand-in: finish pulses lat cycles after start, returns data ^ 8'h99.
    int lat    = 3;
    int rcnt   = 0;
    bit spi_en = 1'b1;
    always @(negedge clk) begin
        m_finish = 1'b0;
        if (rst) rcnt = 0;
        else if (spi_en && m_start) rcnt = lat;
        else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                m_finish   = 1'b1;
                m_data_out = m_data_in ^ 8'h99;
            end
        end
    end

    // Timeline model: each transfer is a start cycle, a done cycle and the first idle cycle.
    int            m_ptr = 0, m_w = 0, m_start_c = 0, m_done_c = BIG, m_idle_first = 0;
    bit            m_active = 1'b0, m_pfin = 1'b0, m_err = 1'b0;
    logic [DW-1:0] e_rdata = '0, e_mdin = '0;
    int            e_sel = 0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = r >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        cyc = cyc + 1;
        if (rst) begin
            m_ptr = 0; m_active = 1'b0; m_start_c = cyc; m_idle_first = cyc; m_done_c = BIG;
            e_rdata = '0; e_mdin = '0; e_sel = 0; m_err = 1'b0;
        end else begin
            if (m_active && cyc > m_done_c) m_active = 1'b0;
            if (m_active && m_done_c == BIG && cyc - 1 >= m_start_c + 1) begin
                if (m_finish && !m_pfin) begin
                    m_done_c = cyc; e_rdata = m_data_out; m_err = 1'b0;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cyc - m_start_c == TO) begin
                    m_done_c = cyc; m_err = 1'b1;
                end
`endif
                if (m_done_c == cyc) begin
                    m_ptr = (m_w + 1) % N;
                    m_idle_first = cyc + GAP + 1;
                end
            end else if (!m_active && cyc - 1 >= m_idle_first) begin
                w = rr_pick(cli.req, m_ptr);
                if (w >= 0) begin
                    m_active = 1'b1; m_w = w; m_start_c = cyc; m_done_c = BIG; m_idle_first = BIG;
                    e_mdin = cli.req_data[w*DW +: DW]; e_sel = w;
                end
            end
        end
        m_pfin = rst ? 1'b0 : m_finish;
    end

    always @(negedge clk) begin
        logic [N-1:0] oh, eg, ed;
        if (cyc > 0) begin
            oh = N'(1 << m_w);
            eg = (m_active && cyc >= m_start_c && cyc <= m_done_c) ? oh : '0;
            ed = (m_active && cyc == m_done_c) ? oh : '0;
            chk("gnt", cli.gnt, eg);
            chk("done", cli.done, ed);
            chk("busy", cli.busy, cyc >= m_start_c && cyc < m_idle_first);
            chk("m_start", m_start, m_active && cyc == m_start_c);
            chk("sel_idx", cli.sel_idx, e_sel);
            chk("rdata", cli.rdata, e_rdata);
            if (eg != '0) chk("m_data_in", m_data_in, e_mdin);
`ifdef SPI_ARB_TIMEOUT_EN
            chk("err", cli.err, (m_err && ed != '0) ? oh : '0);
`endif
        end
    end

    task automatic wait_start(output int n);
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (m_start) return;
        end
        total++; bad++;
        $display("FAIL start_timeout: no m_start within 50 cycles (cycle %0d)", cyc);
    endtask

    task automatic wait_done(input int bound);
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (cli.done != '0) return;
        end
        total++; bad++;
        $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", bound, cyc);
    endtask

    int n, s;
    int ord[5];
    logic [DW-1:0] dat[5];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] exp_dat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        cli.req      = '0;
        cli.req_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_gnt", cli.gnt, 0);
        chk("rst_busy", cli.busy, 0);
        chk("rst_rdata", cli.rdata, 0);
        chk("rst_mstart", m_start, 0);

        // Single request
        cli.req_data[7:0] = 8'hA5;
        cli.req = 4'b0001;
        wait_start(n);
        chk("t1_latency", n, 1);
        chk("t1_mdin", m_data_in, 8'hA5);
        wait_done(60);
        chk("t1_done", cli.done, 4'b0001);
        chk("t1_rdata", cli.rdata, 8'h3C);
        cli.req = '0;
        @(negedge clk); chk("t1_gap0_busy", cli.busy, 1);
        @(negedge clk); chk("t1_gap1_busy", cli.busy, 1);
        @(negedge clk); chk("t1_idle_busy", cli.busy, 0);

        // All requesters active from a fresh pointer
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        cli.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        cli.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(n);
            ord[k] = int'(cli.sel_idx);
            dat[k] = m_data_in;
            wait_done(60);
            if (k == 4) cli.req = '0;
        end
        for (int k = 0; k < 5; k++) begin
            chk("t2_order", ord[k], exp_ord[k]);
            chk("t2_data", dat[k], exp_dat[k]);
        end
        repeat (3) @(negedge clk);

        // Pointer wrap after requester 3
        cli.req = 4'b1000;
        wait_start(n); chk("t3_first", cli.sel_idx, 3);
        wait_done(60); cli.req = '0;
        repeat (3) @(negedge clk);
        cli.req = 4'b1001;
        wait_start(n); chk("t3_wrap", cli.sel_idx, 0);
        wait_done(60); cli.req = '0;
        repeat (3) @(negedge clk);

        // Request dropped during WAIT
        cli.req = 4'b0010;
        wait_start(n); chk("t4_sel", cli.sel_idx, 1);
        @(negedge clk); cli.req = 4'b0100;
        wait_done(60); chk("t4_done", cli.done, 4'b0010);
        wait_start(n); chk("t4_next", cli.sel_idx, 2);
        wait_done(60); cli.req = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of WAIT
        lat = 10;
        cli.req = 4'b0100;
        wait_start(n);
        repeat (2) @(negedge clk);
        rst = 1'b1; cli.req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_gnt", cli.gnt, 0);
        chk("t5_busy", cli.busy, 0);
        chk("t5_mdin", m_data_in, 0);
        chk("t5_sel", cli.sel_idx, 0);
        lat = 3;
        repeat (12) @(negedge clk);
        cli.req = 4'b0100;
        wait_start(n);
        chk("t5_latency", n, 1);
        chk("t5_sel2", cli.sel_idx, 2);
        wait_done(60);
        chk("t5_rdata", cli.rdata, 8'hAA);
        cli.req = '0;
        repeat (3) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog with m_finish never rising
        spi_en = 1'b0;
        cli.req = 4'b0001;
        wait_start(n);
        s = cyc;
        wait_done(40);
        chk("t6_delay", cyc - s, TO);
        chk("t6_err", cli.err, 4'b0001);
        chk("t6_rdata", cli.rdata, 8'hAA);
        cli.req = '0;
        spi_en = 1'b1;
        repeat (3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
